alu32_exerciser: RTL

Sequential driver/checker for the opposite end of the 32-bit add/sub ALU interface. It accepts test vectors over a valid/ready stream, drives sub_add/a/b into the ALU, waits a programmable settle time, and samples result/carry/zero/overflow. It compares these against the expected values and keeps pass/fail statistics. It sits between a vector source (ROM or testbench) and the ALU under test.

---
 rtl/alu32_exerciser_pkg.sv | 20 ++
 rtl/alu32_vec_compare.sv | 24 ++
 rtl/alu32_exerciser.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu32_exerciser_pkg.sv
// Shared types and constants for the 32-bit add/sub ALU exerciser and its comparator.
package alu32_exerciser_pkg;

    localparam int DATA_W = 32;

    // Bit positions inside the 4-bit mismatch mask {result, carry, zero, overflow}.
    localparam int MASK_RES = 3;
    localparam int MASK_CRY = 2;
    localparam int MASK_ZER = 1;
    localparam int MASK_OVF = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/alu32_vec_compare.sv
// Combinational actual-vs-expected comparator for ALU result and flags.
module alu32_vec_compare
    import alu32_exerciser_pkg::*;
(
    input  logic [DATA_W-1:0] act_result_i,
    input  logic              act_carry_i,
    input  logic              act_zero_i,
    input  logic              act_overflow_i,
    input  logic [DATA_W-1:0] exp_result_i,
    input  logic              exp_carry_i,
    input  logic              exp_zero_i,
    input  logic              exp_overflow_i,
    output logic [3:0]        mask_o
);

    always_comb begin
        mask_o           = '0;
        mask_o[MASK_RES] = (act_result_i != exp_result_i);
        mask_o[MASK_CRY] = (act_carry_i != exp_carry_i);
        mask_o[MASK_ZER] = (act_zero_i != exp_zero_i);
        mask_o[MASK_OVF] = (act_overflow_i != exp_overflow_i);
    end

endmodule

// File: rtl/alu32_exerciser.sv
// Vector-driven exerciser: feeds operands to an external add/sub ALU, waits, checks, keeps stats.
module alu32_exerciser
    import alu32_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic               vec_sub_add,
    input  logic [DATA_W-1:0]  vec_a,
    input  logic [DATA_W-1:0]  vec_b,
    input  logic [DATA_W-1:0]  vec_exp_result,
    input  logic               vec_exp_carry,
    input  logic               vec_exp_zero,
    input  logic               vec_exp_overflow,
    input  logic               vec_last,
    output logic               alu_sub_add,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    output logic               busy,
    output logic               done,
    output logic               err_valid,
    output logic [3:0]         err_mask,
    output logic [COUNT_W-1:0] pass_count,
    output logic [COUNT_W-1:0] fail_count,
    output logic               first_fail_valid,
    output logic [COUNT_W-1:0] first_fail_index,
    output state_t             dbg_state
);

    // Handshake: a vector transfers on a rising edge where vec_valid and vec_ready are both high;
    // vec_ready depends only on the state, and the source must hold its fields while vec_valid is high.

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t              state_q;
    logic [7:0]          settle_q;
    logic                sub_q, exp_c_q, exp_z_q, exp_o_q, last_q;
    logic [DATA_W-1:0]   a_q, b_q, exp_res_q;
    logic [COUNT_W-1:0]  pass_q, fail_q, idx_q, ffi_q;
    logic [COUNT_W-1:0]  pass_d, fail_d, idx_d;
    logic                ffv_q, err_valid_q;
    logic [3:0]          err_mask_q;
    logic [3:0]          mask;

    alu32_vec_compare u_cmp (
        .act_result_i   (alu_result),
        .act_carry_i    (alu_carry),
        .act_zero_i     (alu_zero),
        .act_overflow_i (alu_overflow),
        .exp_result_i   (exp_res_q),
        .exp_carry_i    (exp_c_q),
        .exp_zero_i     (exp_z_q),
        .exp_overflow_i (exp_o_q),
        .mask_o         (mask)
    );

    // Saturating increments: statistics stick at all-ones rather than wrapping.
    assign pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + COUNT_W'(1);
    assign fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + COUNT_W'(1);
    assign idx_d  = (idx_q  == CNT_MAX) ? idx_q  : idx_q  + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            exp_res_q   <= '0;
            exp_c_q     <= 1'b0;
            exp_z_q     <= 1'b0;
            exp_o_q     <= 1'b0;
            last_q      <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            idx_q       <= '0;
            ffv_q       <= 1'b0;
            ffi_q       <= '0;
            err_valid_q <= 1'b0;
            err_mask_q  <= '0;
        end else begin
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= FETCH;
                        pass_q  <= '0;
                        fail_q  <= '0;
                        idx_q   <= '0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= '0;
                    end
                end
                FETCH: begin
                    if (vec_valid) begin
                        sub_q     <= vec_sub_add;
                        a_q       <= vec_a;
                        b_q       <= vec_b;
                        exp_res_q <= vec_exp_result;
                        exp_c_q   <= vec_exp_carry;
                        exp_z_q   <= vec_exp_zero;
                        exp_o_q   <= vec_exp_overflow;
                        last_q    <= vec_last;
                        settle_q  <= 8'(SETTLE_CYCLES - 1);
                        state_q   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == 8'd0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                CHECK: begin
                    if (mask == 4'd0) begin
                        pass_q <= pass_d;
                    end else begin
                        fail_q      <= fail_d;
                        err_valid_q <= 1'b1;
                        err_mask_q  <= mask;
                        if (!ffv_q) begin
                            ffv_q <= 1'b1;
                            ffi_q <= idx_q;
                        end
                    end
                    idx_q   <= idx_d;
                    state_q <= last_q ? DONE : FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_ready        = (state_q == FETCH);
    assign busy             = (state_q == FETCH) || (state_q == SETTLE) || (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign alu_sub_add      = sub_q;
    assign alu_a            = a_q;
    assign alu_b            = b_q;
    assign err_valid        = err_valid_q;
    assign err_mask         = err_mask_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_index = ffi_q;
    assign dbg_state        = state_q;

endmodule
